// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and count types for the timing generator and pixel generator.
package vga_pkg;

  localparam int unsigned VGA_CLK_DIV    = 4;
  localparam int unsigned VGA_GEN_FRAMES = 30;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  localparam int unsigned VGA_H_W     = $clog2(VGA_H_TOTAL);
  localparam int unsigned VGA_V_W     = $clog2(VGA_V_TOTAL);
  localparam int unsigned VGA_FRAME_W = 8;

  typedef logic [VGA_H_W-1:0] hcount_t;
  typedef logic [VGA_V_W-1:0] vcount_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: enabled wrap counter 0..MAX with a registered active-low sync decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned W          = VGA_H_W,
  parameter int unsigned MAX        = VGA_H_TOTAL - 1,
  parameter int unsigned SYNC_START = VGA_H_SYNC_START,
  parameter int unsigned SYNC_END   = VGA_H_SYNC_END
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         sync_n,
  output logic         wrap_c
);

  logic [W-1:0] count_d, count_q;
  logic         sync_n_d, sync_n_q;

  // Sync is decoded from the next count so it moves in the same clock as the count.
  always_comb begin
    count_d  = count_q;
    wrap_c   = en && (count_q == W'(MAX));
    if (en) begin
      count_d = wrap_c ? '0 : count_q + W'(1);
    end
    sync_n_d = !((count_d >= W'(SYNC_START)) && (count_d <= W'(SYNC_END)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      sync_n_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      sync_n_q <= sync_n_d;
    end
  end

  assign count  = count_q;
  assign sync_n = sync_n_q;

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing: pixel-rate divider, H/V counters with sync, frame strobe and
// Game-of-Life generation strobe (auto every GEN_FRAMES frames while running, or on request).
module vga_timing_generator
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV    = VGA_CLK_DIV,
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter int unsigned GEN_FRAMES = VGA_GEN_FRAMES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       stepReq,
  output logic       pixTick,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       frameStart,
  output logic       genTick
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
  localparam int unsigned DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]       div_cnt_d, div_cnt_q;
  logic                   pix_tick_d, pix_tick_q;
  logic                   frame_start_d, frame_start_q;
  logic                   gen_tick_d, gen_tick_q;
  logic                   step_pending_d, step_pending_q;
  logic [VGA_FRAME_W-1:0] frame_cnt_d, frame_cnt_q;

  logic    pix_en_c;
  logic    h_wrap_c;
  logic    v_wrap_c;
  logic    step_c;
  logic    expire_c;
  hcount_t h_count;
  vcount_t v_count;
  logic    h_sync_n;
  logic    v_sync_n;

  // Pixel enable is the divider wrap; pixTick is its registered copy, aligned with the count update.
  always_comb begin
    pix_en_c   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    div_cnt_d  = pix_en_c ? '0 : div_cnt_q + DIV_W'(1);
    pix_tick_d = pix_en_c;
  end

  vga_axis_counter #(
    .W          (VGA_H_W),
    .MAX        (H_TOTAL - 1),
    .SYNC_START (H_SYNC_START),
    .SYNC_END   (H_SYNC_END)
  ) u_h_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (pix_en_c),
    .count  (h_count),
    .sync_n (h_sync_n),
    .wrap_c (h_wrap_c)
  );

  vga_axis_counter #(
    .W          (VGA_V_W),
    .MAX        (V_TOTAL - 1),
    .SYNC_START (V_SYNC_START),
    .SYNC_END   (V_SYNC_END)
  ) u_v_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (h_wrap_c),
    .count  (v_count),
    .sync_n (v_sync_n),
    .wrap_c (v_wrap_c)
  );

  // Generation control acts only on the raster wrap; a request sampled on that same edge is consumed there.
  always_comb begin
    frame_start_d  = v_wrap_c;
    frame_cnt_d    = frame_cnt_q;
    step_pending_d = step_pending_q | stepReq;
    gen_tick_d     = 1'b0;
    step_c         = step_pending_q | stepReq;
    expire_c       = run && (frame_cnt_q == VGA_FRAME_W'(GEN_FRAMES - 1));
    if (v_wrap_c) begin
      gen_tick_d = step_c | expire_c;
      if (run) begin
        frame_cnt_d = (step_c | expire_c) ? '0 : frame_cnt_q + VGA_FRAME_W'(1);
      end
      if (step_c | expire_c) begin
        step_pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q      <= '0;
      pix_tick_q     <= 1'b0;
      frame_start_q  <= 1'b0;
      gen_tick_q     <= 1'b0;
      step_pending_q <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      pix_tick_q     <= pix_tick_d;
      frame_start_q  <= frame_start_d;
      gen_tick_q     <= gen_tick_d;
      step_pending_q <= step_pending_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  assign pixTick    = pix_tick_q;
  assign hCount     = h_count;
  assign vCount     = v_count;
  assign hSync      = h_sync_n;
  assign vSync      = v_sync_n;
  assign frameStart = frame_start_q;
  assign genTick    = gen_tick_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: a default-size instance and a shrunken-raster instance,
// each compared every clock against a time-based reference model through a scoreboard queue.
module tb_vga_timing_generator;

  localparam int B_D  = 2;
  localparam int B_HA = 12;
  localparam int B_HF = 2;
  localparam int B_HS = 3;
  localparam int B_HB = 3;
  localparam int B_VA = 6;
  localparam int B_VF = 2;
  localparam int B_VS = 2;
  localparam int B_VB = 2;
  localparam int B_GF = 3;
  localparam int B_FRAME_CLKS = B_D * (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB);

  typedef struct {
    longint d, ha, hf, hs, hb, va, vf, vs, vb, gf;
  } cfg_t;

  typedef struct packed {
    logic       pix;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       gt;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n, run, stepReq;

  logic       a_pix, a_hs, a_vs, a_fs, a_gt;
  logic [9:0] a_h, a_v;
  logic       b_pix, b_hs, b_vs, b_fs, b_gt;
  logic [9:0] b_h, b_v;

  int checks = 0;
  int errors = 0;

  obs_t   a_q[$];
  obs_t   b_q[$];
  longint t_cnt;
  longint runs[2];
  bit     pend[2];

  always #5 clk = ~clk;

  vga_timing_generator dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .stepReq(stepReq),
    .pixTick(a_pix), .hCount(a_h), .vCount(a_v), .hSync(a_hs), .vSync(a_vs),
    .frameStart(a_fs), .genTick(a_gt)
  );

  vga_timing_generator #(
    .CLK_DIV(B_D), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .GEN_FRAMES(B_GF)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .stepReq(stepReq),
    .pixTick(b_pix), .hCount(b_h), .vCount(b_v), .hSync(b_hs), .vSync(b_vs),
    .frameStart(b_fs), .genTick(b_gt)
  );

  function automatic cfg_t cfg_of(input int c);
    cfg_t f;
    if (c == 0) f = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 30};
    else        f = '{B_D, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, B_GF};
    return f;
  endfunction

  // Raster state after t clocks since reset release, straight from the timing arithmetic.
  function automatic obs_t raster(input int c, input longint t);
    cfg_t   f;
    longint ht, vt, p, h, v;
    obs_t   e;
    f  = cfg_of(c);
    ht = f.ha + f.hf + f.hs + f.hb;
    vt = f.va + f.vf + f.vs + f.vb;
    p  = t / f.d;
    h  = p % ht;
    v  = (p / ht) % vt;
    e.pix = (t > 0) && ((t % f.d) == 0);
    e.h   = 10'(h);
    e.v   = 10'(v);
    e.hs  = !((h >= f.ha + f.hf) && (h < f.ha + f.hf + f.hs));
    e.vs  = !((v >= f.va + f.vf) && (v < f.va + f.vf + f.vs));
    e.fs  = e.pix && (p > 0) && ((p % (ht * vt)) == 0);
    e.gt  = 1'b0;
    return e;
  endfunction

  task automatic cmp_obs(input string nm, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t t=%0d got pix=%0b h=%0d v=%0d hs=%0b vs=%0b fs=%0b gt=%0b required pix=%0b h=%0d v=%0d hs=%0b vs=%0b fs=%0b gt=%0b",
               nm, $time, t_cnt, got.pix, got.h, got.v, got.hs, got.vs, got.fs, got.gt,
               exp.pix, exp.h, exp.v, exp.hs, exp.vs, exp.fs, exp.gt);
    end
  endtask

  task automatic cmp_int(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s @%0t got %0d required %0d", nm, $time, got, exp);
    end
  endtask

  // Reference model: one expected observation per instance per clock edge.
  always @(posedge clk) begin
    obs_t   e;
    cfg_t   f;
    if (!rst_n) t_cnt = 0;
    else        t_cnt = t_cnt + 1;
    for (int c = 0; c < 2; c++) begin
      f = cfg_of(c);
      e = raster(c, t_cnt);
      if (!rst_n) begin
        runs[c] = 0;
        pend[c] = 1'b0;
      end else if (e.fs) begin
        if (run) runs[c] = runs[c] + 1;
        e.gt = pend[c] || stepReq || (run && runs[c] == f.gf);
        if (e.gt) begin
          pend[c] = 1'b0;
          if (run) runs[c] = 0;
        end
      end else if (stepReq) begin
        pend[c] = 1'b1;
      end
      if (c == 0) a_q.push_back(e);
      else        b_q.push_back(e);
    end
  end

  // Monitor: pop and compare mid-cycle; entries landing while reset is held are discarded.
  always @(negedge clk) begin
    obs_t ea, eb;
    if (a_q.size() == 0 || b_q.size() == 0) begin
      cmp_int("sb_empty", longint'(a_q.size() + b_q.size()), 2);
    end else begin
      ea = a_q.pop_front();
      eb = b_q.pop_front();
      if (rst_n) begin
        cmp_obs("dut_a_raster", {a_pix, a_h, a_v, a_hs, a_vs, a_fs, a_gt}, ea);
        cmp_obs("dut_b_raster", {b_pix, b_h, b_v, b_hs, b_vs, b_fs, b_gt}, eb);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic rand_cycles(input int n, input bit toggle_run);
    repeat (n) begin
      @(posedge clk);
      #2;
      stepReq = ($urandom_range(0, 299) == 0);
      if (toggle_run && $urandom_range(0, 1499) == 0) run = ~run;
    end
    stepReq = 1'b0;
  endtask

  initial begin
    int  gt_count;
    bit  found;
    rst_n   = 1'b0;
    run     = 1'b0;
    stepReq = 1'b0;
    idle(3);
    #1;
    cmp_obs("reset_state_a", {a_pix, a_h, a_v, a_hs, a_vs, a_fs, a_gt}, raster(0, 0));
    cmp_obs("reset_state_b", {b_pix, b_h, b_v, b_hs, b_vs, b_fs, b_gt}, raster(1, 0));
    #1;
    rst_n = 1'b1;

    // First line of the full-size raster plus several small frames with stray step requests.
    rand_cycles(3400, 1'b0);

    // Fresh start with run held high: generation strobe on frames 3, 6 and 9 only.
    rst_n = 1'b0;
    idle(2);
    run   = 1'b1;
    rst_n = 1'b1;
    gt_count = 0;
    repeat (10 * B_FRAME_CLKS + 4) begin
      @(posedge clk);
      #2;
      if (b_gt) gt_count++;
    end
    cmp_int("run_gen_count", gt_count, 10 / B_GF);

    // Stopped: mid-frame request, then a request issued while frameStart is high.
    run = 1'b0;
    idle(37);
    stepReq = 1'b1;
    idle(1);
    stepReq = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 2 * B_FRAME_CLKS && !found; k++) begin
      @(posedge clk);
      #2;
      if (b_fs) found = 1'b1;
    end
    if (!found) cmp_int("wait_frame_start", 0, 1);
    stepReq = 1'b1;
    idle(1);
    stepReq = 1'b0;
    idle(B_FRAME_CLKS + 20);

    // Request sampled on the very edge that wraps the raster.
    found = 1'b0;
    for (int k = 0; k < 2 * B_FRAME_CLKS && !found; k++) begin
      @(posedge clk);
      #2;
      if (b_pix && b_h == 10'(B_HA + B_HF + B_HS + B_HB - 1) && b_v == 10'(B_VA + B_VF + B_VS + B_VB - 1))
        found = 1'b1;
    end
    if (!found) cmp_int("wait_last_pixel", 0, 1);
    idle(1);
    stepReq = 1'b1;
    idle(1);
    stepReq = 1'b0;
    idle(B_FRAME_CLKS);

    run = 1'b1;
    rand_cycles(10000, 1'b1);

    // Asynchronous reset in the middle of the vertical sync pulse.
    found = 1'b0;
    for (int k = 0; k < 2 * B_FRAME_CLKS && !found; k++) begin
      @(posedge clk);
      #2;
      if (b_v == 10'(B_VA + B_VF + 1) && b_h == 10'(B_HA + B_HF + 1)) found = 1'b1;
    end
    if (!found) cmp_int("wait_vsync_mid", 0, 1);
    cmp_int("vsync_low_before_reset", longint'(b_vs), 0);
    rst_n = 1'b0;
    #1;
    cmp_obs("async_reset_a", {a_pix, a_h, a_v, a_hs, a_vs, a_fs, a_gt}, raster(0, 0));
    cmp_obs("async_reset_b", {b_pix, b_h, b_v, b_hs, b_vs, b_fs, b_gt}, raster(1, 0));
    idle(3);
    rst_n = 1'b1;
    rand_cycles(1500, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Produces the 640x480@60 Hz VGA raster: a pixel-rate tick, the free-running horizontal/vertical counters, registered active-low sync pulses, and frame/generation event strobes. Its `hCount`/`vCount` outputs are the counter inputs consumed by the pixel generator (10-bit, 0..799 / 0..524). `genTick` paces the Game-of-Life update engine so cell state only changes at frame boundaries.

## Interface
- `CLK_DIV`, 4: system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16.
- `H_ACTIVE`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal total 800.
- `V_ACTIVE`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical total 525.
- `GEN_FRAMES`, 30: frames per generation step while running; legal range 1..255.
- `clk`  in  1  system clock; one clock domain, all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; deassertion synchronous to `clk` is the caller's responsibility.
- `run`  in  1  level; 1 = auto-advance generations every `GEN_FRAMES` frames.
- `stepReq`  in  1  one-clk pulse; request one generation at the next frame start.
- `pixTick`  out  1  one-clk pulse per pixel period.
- `hCount`  out  10  horizontal position, 0..799.
- `vCount`  out  10  vertical position, 0..524.
- `hSync`  out  1  active-low horizontal sync.
- `vSync`  out  1  active-low vertical sync.
- `frameStart`  out  1  one-clk pulse when the raster wraps to (0,0).
- `genTick`  out  1  one-clk pulse; Game-of-Life step strobe, coincident with `frameStart`.

## Operation
- Divider `divCnt` counts 0..CLK_DIV-1 and wraps. `pixTick` is a register set high in the clk where `divCnt` wraps to 0. CLK_DIV=1 gives `pixTick` constantly high after the first clk.
- On a clk with `pixTick`=1:
  - `hCount` increments; 799 wraps to 0.
  - `vCount` increments only on an `hCount` wrap; 524 wraps to 0.
- Sync decodes are registered from the next count values, so they change in the same clk as the counts.
  - `hSync`=0 iff `hCount` in 656..751.
  - `vSync`=0 iff `vCount` in 490..491.
- `frameStart`=1 for the single clk in which the counts transition from (799,524) to (0,0). It does not fire for the (0,0) state entered by reset.
- Generation control, evaluated only in a `frameStart` clk:
  - 8-bit `frameCnt`; `stepPending` latch, set by `stepReq` and cleared when `genTick` fires.
  - If `run`=1: when `frameCnt`==GEN_FRAMES-1, set `genTick`=1 and clear `frameCnt`; otherwise increment `frameCnt`.
  - If `run`=0: `frameCnt` holds.
  - `stepPending`=1 forces `genTick`=1, and also clears `frameCnt` when `run`=1.
- Simultaneous events:
  - Counter expiry plus a pending step produce exactly one `genTick`.
  - `stepReq` arriving in the same clk as `frameStart` counts for that frame.
  - `run` falling clears nothing; `frameCnt` resumes from its held value.
- All outputs are registered; no combinational input-to-output paths.

## Timing
- Reset values:
  - `hCount`=0, `vCount`=0, `divCnt`=0, `frameCnt`=0.
  - `hSync`=1, `vSync`=1.
  - `pixTick`=0, `frameStart`=0, `genTick`=0, `stepPending`=0.
- First `pixTick` arrives in clk CLK_DIV after reset release, where clk 1 is the first edge with `rst_n`=1.
- Each count value holds for exactly CLK_DIV clks. Line = 800*CLK_DIV clks; frame = 420000*CLK_DIV clks.
- `genTick` latency from `stepReq`: at most one frame.
- Reset asserted mid-frame forces all state to reset values immediately (asynchronously), with no pulse emitted on release.

## Structure
- Package `vga_pkg`:
  - Timing constants (H/V active, porch, sync, totals).
  - Derived sync start/end positions.
  - `hcount_t`/`vcount_t` typedefs as logic [$clog2(800)-1:0] / [$clog2(525)-1:0], shared with the pixel generator.
- Sub-module `vga_axis_counter`: parameterised wrap counter (`MAX`, `SYNC_START`, `SYNC_END`) with an enable in and a wrap-flag out. Instantiated twice, for H (enable = `pixTick`) and for V (enable = `pixTick` & H wrap).

## Test plan
- Reset release with CLK_DIV=4 -> `pixTick` in clk 4; `hCount`=1 from clk 4 to 7; `hSync`=`vSync`=1 through clk 2623.
- Run one line -> `hSync` low for exactly 96*4=384 clks starting at the clk where `hCount`=656; `vCount` steps 0->1 at the `hCount` 799->0 edge.
- Run full frame -> `vSync` low for exactly 2 lines from `vCount`=490; `frameStart` single clk at 1,680,000 clks; none at reset.
- `run`=1, GEN_FRAMES=3 -> `genTick` on frame-start 3, 6 and 9 only, each coincident with `frameStart`.
- `run`=0, `stepReq` pulse mid-frame -> exactly one `genTick` at the next `frameStart`; a second `stepReq` issued in that same clk -> `genTick` again on the following frame.
- Assert `rst_n`=0 at `hCount`=700, `vCount`=491 -> all outputs at reset values within the same clk (asynchronous); `vSync` returns to 1 without completing the pulse.
